// File: rtl/id_ex_operand_stage_if.sv
// ============================================================================
// Module   : id_ex_operand_stage_if
// Brief    : Decode-side, hazard and ALU-side signals of the ID/EX operand stage
// Revision : 1.0
// ============================================================================
`default_nettype none

interface id_ex_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [REG_ADDR_W-1:0] Rs1Addr;
  logic [REG_ADDR_W-1:0] Rs2Addr;
  logic [XLEN-1:0]       Rs1Data;
  logic [XLEN-1:0]       Rs2Data;
  logic [XLEN-1:0]       Pc;
  logic [XLEN-1:0]       Imm;
  logic                  ALUSrcA;
  logic                  ALUSrcB;
  logic [3:0]            ALUControlIn;
  logic [REG_ADDR_W-1:0] RdIn;
  logic                  ExMemRegWrite;
  logic [REG_ADDR_W-1:0] ExMemRd;
  logic [XLEN-1:0]       ExMemData;
  logic                  MemWbRegWrite;
  logic [REG_ADDR_W-1:0] MemWbRd;
  logic [XLEN-1:0]       MemWbData;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       A;
  logic [XLEN-1:0]       B;
  logic [3:0]            ALUControl;
  logic [XLEN-1:0]       StoreData;
  logic [REG_ADDR_W-1:0] Rd;
  logic                  IllegalOp;

  modport slave (
    input  in_valid, flush, Rs1Addr, Rs2Addr, Rs1Data, Rs2Data, Pc, Imm,
           ALUSrcA, ALUSrcB, ALUControlIn, RdIn,
           ExMemRegWrite, ExMemRd, ExMemData,
           MemWbRegWrite, MemWbRd, MemWbData, out_ready,
    output in_ready, out_valid, A, B, ALUControl, StoreData, Rd, IllegalOp
  );

  modport master (
    output in_valid, flush, Rs1Addr, Rs2Addr, Rs1Data, Rs2Data, Pc, Imm,
           ALUSrcA, ALUSrcB, ALUControlIn, RdIn,
           ExMemRegWrite, ExMemRd, ExMemData,
           MemWbRegWrite, MemWbRd, MemWbData, out_ready,
    input  in_ready, out_valid, A, B, ALUControl, StoreData, Rd, IllegalOp
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// ============================================================================
// Module   : id_ex_operand_stage
// Brief    : ID/EX register stage with EX/MEM and MEM/WB operand forwarding
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_operand_stage_if.slave bus
);

  localparam logic [3:0] c_alu_add  = 4'b0000;
  localparam logic [3:0] c_alu_sub  = 4'b0001;
  localparam logic [3:0] c_alu_and  = 4'b0010;
  localparam logic [3:0] c_alu_or   = 4'b0011;
  localparam logic [3:0] c_alu_slt  = 4'b0101;
  localparam logic [3:0] c_alu_sll  = 4'b0110;
  localparam logic [3:0] c_alu_srl  = 4'b0111;
  localparam logic [3:0] c_alu_xor  = 4'b1000;
  localparam logic [3:0] c_alu_sltu = 4'b1001;

  logic                  r_valid;
  logic [XLEN-1:0]       r_a;
  logic [XLEN-1:0]       r_b;
  logic [XLEN-1:0]       r_store;
  logic [3:0]            r_ctrl;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_illegal;

  logic                  w_in_ready;
  logic                  w_capture;
  logic [XLEN-1:0]       w_fwd_rs1;
  logic [XLEN-1:0]       w_fwd_rs2;
  logic                  w_legal;

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is hardwired zero
  always_comb begin
    w_fwd_rs1 = bus.Rs1Data;
    if (bus.Rs1Addr != '0) begin
      if (bus.ExMemRegWrite && (bus.ExMemRd == bus.Rs1Addr))
        w_fwd_rs1 = bus.ExMemData;
      else if (bus.MemWbRegWrite && (bus.MemWbRd == bus.Rs1Addr))
        w_fwd_rs1 = bus.MemWbData;
    end
  end

  always_comb begin
    w_fwd_rs2 = bus.Rs2Data;
    if (bus.Rs2Addr != '0) begin
      if (bus.ExMemRegWrite && (bus.ExMemRd == bus.Rs2Addr))
        w_fwd_rs2 = bus.ExMemData;
      else if (bus.MemWbRegWrite && (bus.MemWbRd == bus.Rs2Addr))
        w_fwd_rs2 = bus.MemWbData;
    end
  end

  always_comb begin
    w_legal = 1'b0;
    case (bus.ALUControlIn)
      c_alu_add, c_alu_sub, c_alu_and, c_alu_or, c_alu_slt,
      c_alu_sll, c_alu_srl, c_alu_xor, c_alu_sltu: w_legal = 1'b1;
      default:                                     w_legal = 1'b0;
    endcase
  end

  // Flush only clears the flags; data registers are meaningless while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_store   <= '0;
      r_ctrl    <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_capture) begin
      r_valid   <= 1'b1;
      r_a       <= bus.ALUSrcA ? bus.Pc  : w_fwd_rs1;
      r_b       <= bus.ALUSrcB ? bus.Imm : w_fwd_rs2;
      r_store   <= w_fwd_rs2;
      r_ctrl    <= bus.ALUControlIn;
      r_rd      <= bus.RdIn;
      r_illegal <= !w_legal;
    end else if (r_valid && bus.out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_valid;
  assign bus.A          = r_a;
  assign bus.B          = r_b;
  assign bus.StoreData  = r_store;
  assign bus.ALUControl = r_ctrl;
  assign bus.Rd         = r_rd;
  assign bus.IllegalOp  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Brief    : Randomized self-checking bench with a transaction-level reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam logic [15:0] LEGAL_MASK = 16'h03EF;

  typedef struct {
    logic          in_valid, flush, out_ready, src_a, src_b, exw, mww;
    logic [RW-1:0] rs1, rs2, rd, exrd, mwrd;
    logic [31:0]   d1, d2, pc, imm, exd, mwd;
    logic [3:0]    ctrl;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

  id_ex_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the ALU should currently be seeing
  logic          exp_valid;
  logic [31:0]   exp_a, exp_b, exp_sd;
  logic [3:0]    exp_ctrl;
  logic [RW-1:0] exp_rd;
  logic          exp_ill;
  logic          ill_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_ref(input stim_t s, input logic [RW-1:0] rs,
                                          input logic [31:0] rf);
    if (rs == 0)                   return rf;
    if (s.exw && s.exrd == rs)     return s.exd;
    if (s.mww && s.mwrd == rs)     return s.mwd;
    return rf;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.in_valid = 0; s.flush = 0; s.out_ready = 1; s.src_a = 0; s.src_b = 0;
    s.exw = 0; s.mww = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.exrd = 0; s.mwrd = 0;
    s.d1 = 0; s.d2 = 0; s.pc = 0; s.imm = 0; s.exd = 0; s.mwd = 0; s.ctrl = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.in_valid  = ($urandom_range(0, 3) != 0);
    s.out_ready = ($urandom_range(0, 3) != 0);
    s.flush     = ($urandom_range(0, 9) == 0);
    s.src_a = 1'($urandom); s.src_b = 1'($urandom);
    s.exw   = 1'($urandom); s.mww   = 1'($urandom);
    s.rs1   = RW'($urandom_range(0, 3)); s.rs2  = RW'($urandom_range(0, 3));
    s.exrd  = RW'($urandom_range(0, 3)); s.mwrd = RW'($urandom_range(0, 3));
    s.rd    = RW'($urandom);
    s.d1 = $urandom; s.d2 = $urandom; s.pc = $urandom; s.imm = $urandom;
    s.exd = $urandom; s.mwd = $urandom;
    s.ctrl = 4'($urandom);
    return s;
  endfunction

  task automatic model_reset();
    exp_valid = 0; exp_a = 0; exp_b = 0; exp_sd = 0; exp_ctrl = 0; exp_rd = 0;
    exp_ill = 0; ill_known = 1;
  endtask

  task automatic apply(input stim_t s);
    bus.in_valid = s.in_valid; bus.flush = s.flush; bus.out_ready = s.out_ready;
    bus.ALUSrcA = s.src_a; bus.ALUSrcB = s.src_b;
    bus.ExMemRegWrite = s.exw; bus.MemWbRegWrite = s.mww;
    bus.Rs1Addr = s.rs1; bus.Rs2Addr = s.rs2; bus.RdIn = s.rd;
    bus.ExMemRd = s.exrd; bus.MemWbRd = s.mwrd;
    bus.Rs1Data = s.d1; bus.Rs2Data = s.d2; bus.Pc = s.pc; bus.Imm = s.imm;
    bus.ExMemData = s.exd; bus.MemWbData = s.mwd; bus.ALUControlIn = s.ctrl;
  endtask

  // One clock: check registered outputs, drive new inputs, check in_ready, advance model
  task automatic cycle(input stim_t s);
    logic take;
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("A", bus.A, exp_a);
      check("B", bus.B, exp_b);
      check("StoreData", bus.StoreData, exp_sd);
      check("ALUControl", 32'(bus.ALUControl), 32'(exp_ctrl));
      check("Rd", 32'(bus.Rd), 32'(exp_rd));
    end
    if (exp_valid || ill_known) check("IllegalOp", 32'(bus.IllegalOp), 32'(exp_ill));
    if (!rst_n) check("reset_A_zero", bus.A, 32'h0);
    apply(s);
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!exp_valid || s.out_ready));
    take = s.in_valid && (!exp_valid || s.out_ready) && !s.flush;
    if (!rst_n) begin
      model_reset();
    end else if (s.flush) begin
      exp_valid = 0; exp_ill = 0; ill_known = 1;
    end else if (take) begin
      exp_valid = 1;
      exp_a     = s.src_a ? s.pc  : fwd_ref(s, s.rs1, s.d1);
      exp_b     = s.src_b ? s.imm : fwd_ref(s, s.rs2, s.d2);
      exp_sd    = fwd_ref(s, s.rs2, s.d2);
      exp_ctrl  = s.ctrl;
      exp_rd    = s.rd;
      exp_ill   = !LEGAL_MASK[s.ctrl];
      ill_known = 1;
    end else if (exp_valid && s.out_ready) begin
      exp_valid = 0; ill_known = 0;
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    model_reset();
    apply(idle_stim());

    // Reset held with a pending instruction: nothing may be captured
    s = idle_stim(); s.in_valid = 1; s.d1 = 32'h55; s.rs1 = 1;
    repeat (3) cycle(s);
    cycle(idle_stim());
    rst_n = 1'b1;
    cycle(idle_stim());

    // Forwarding priority: EX/MEM beats MEM/WB, then MEM/WB alone
    s = idle_stim(); s.in_valid = 1; s.rs1 = 5; s.d1 = 32'h11;
    s.exw = 1; s.exrd = 5; s.exd = 32'h22; s.mww = 1; s.mwrd = 5; s.mwd = 32'h33;
    cycle(s);
    post_edge();
    check("fwd_exmem_A", bus.A, 32'h22);
    s.exw = 0;
    cycle(s);
    post_edge();
    check("fwd_memwb_A", bus.A, 32'h33);

    // x0 must never be forwarded
    s = idle_stim(); s.in_valid = 1; s.rs2 = 0; s.d2 = 0;
    s.exw = 1; s.exrd = 0; s.exd = 32'hDEAD;
    cycle(s);
    post_edge();
    check("x0_B", bus.B, 32'h0);
    check("x0_StoreData", bus.StoreData, 32'h0);

    // Operand select: PC and immediate, store data still from rs2
    s = idle_stim(); s.in_valid = 1; s.src_a = 1; s.pc = 32'h100;
    s.src_b = 1; s.imm = 32'hFFFF_FFFC; s.rs2 = 3; s.d2 = 32'h7; s.ctrl = 4'b0000;
    cycle(s);
    post_edge();
    check("sel_A", bus.A, 32'h100);
    check("sel_B", bus.B, 32'hFFFF_FFFC);
    check("sel_StoreData", bus.StoreData, 32'h7);
    check("sel_ALUControl", 32'(bus.ALUControl), 32'h0);

    // Stall three cycles, then back-to-back throughput
    repeat (3) begin
      s = rand_stim(); s.in_valid = 1; s.out_ready = 0; s.flush = 0;
      cycle(s);
    end
    repeat (8) begin
      s = rand_stim(); s.in_valid = 1; s.out_ready = 1; s.flush = 0;
      cycle(s);
    end

    // Illegal opcode is captured and flagged, then flush beats stall and capture
    s = idle_stim(); s.in_valid = 1; s.ctrl = 4'b0100; s.rd = 7;
    cycle(s);
    post_edge();
    check("illegal_flag", 32'(bus.IllegalOp), 32'h1);
    check("illegal_valid", 32'(bus.out_valid), 32'h1);
    s = idle_stim(); s.in_valid = 1; s.out_ready = 0; s.flush = 1; s.ctrl = 4'b0001;
    cycle(s);
    post_edge();
    check("flush_valid", 32'(bus.out_valid), 32'h0);
    check("flush_illegal", 32'(bus.IllegalOp), 32'h0);
    cycle(idle_stim());

    // Randomized traffic against the model
    repeat (400) cycle(rand_stim());

    // Asynchronous reset while stalled drops the held instruction at once
    s = idle_stim(); s.in_valid = 1; s.out_ready = 0; s.d1 = 32'hABCD; s.rs1 = 9;
    cycle(s);
    cycle(s);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'h0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'h1);
    model_reset();
    apply(idle_stim());
    cycle(idle_stim());
    rst_n = 1'b1;
    cycle(idle_stim());
    cycle(idle_stim());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
